mem_arbiter: RTL

- Two-requester controller that shares one single-port MemoryChip between the OLED refresh reader (requester 0) and the host command writer (requester 1).
- Arbitrates round-robin and accepts requests with a valid/ready handshake.
- Drives the chip's active-low WE_bar/CS_bar strobes from registers and returns read data with an rvalid pulse to the requester that issued the read.
- Sits between the display datapath and MemoryChip; it is the only driver of the chip's pins.

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two requesters and the MemoryChip pins.
// The master side is the requesters plus the chip; the slave side is the arbiter.
interface mem_arbiter_if #(
    parameter int nCells    = 8,
    parameter int WORD_SIZE = 8
);
    localparam int AW = (nCells > 1) ? $clog2(nCells) : 1;

    logic                 r0_valid;
    logic                 r0_ready;
    logic                 r0_we;
    logic [AW-1:0]        r0_addr;
    logic [WORD_SIZE-1:0] r0_wdata;
    logic                 r0_rvalid;
    logic [WORD_SIZE-1:0] r0_rdata;

    logic                 r1_valid;
    logic                 r1_ready;
    logic                 r1_we;
    logic [AW-1:0]        r1_addr;
    logic [WORD_SIZE-1:0] r1_wdata;
    logic                 r1_rvalid;
    logic [WORD_SIZE-1:0] r1_rdata;

    logic                 mem_WE_bar;
    logic                 mem_CS_bar;
    logic [AW-1:0]        mem_Address;
    logic [WORD_SIZE-1:0] mem_DataIn;
    logic [WORD_SIZE-1:0] mem_DataOut;

    logic                 busy;

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        output mem_DataOut,
        input  r0_ready, r0_rvalid, r0_rdata,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  mem_WE_bar, mem_CS_bar, mem_Address, mem_DataIn,
        input  busy
    );

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        input  mem_DataOut,
        output r0_ready, r0_rvalid, r0_rdata,
        output r1_ready, r1_rvalid, r1_rdata,
        output mem_WE_bar, mem_CS_bar, mem_Address, mem_DataIn,
        output busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-requester controller for a single-port MemoryChip with
// registered active-low strobes and per-requester read-response pulses.
module mem_arbiter #(
    parameter int nCells    = 8,
    parameter int WORD_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int AW = (nCells > 1) ? $clog2(nCells) : 1;
    localparam logic [AW:0] CELL_LIMIT = (AW + 1)'(nCells);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]           req_valid;
    logic [1:0]           req_we;
    logic [AW-1:0]        req_addr  [2];
    logic [WORD_SIZE-1:0] req_wdata [2];
    logic [1:0]           req_in_range;

    assign req_valid    = {bus.r1_valid, bus.r0_valid};
    assign req_we       = {bus.r1_we, bus.r0_we};
    assign req_addr[0]  = bus.r0_addr;
    assign req_addr[1]  = bus.r1_addr;
    assign req_wdata[0] = bus.r0_wdata;
    assign req_wdata[1] = bus.r1_wdata;

    // Only non-power-of-two depths can present addresses past the last cell.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_range
            assign req_in_range[gi] = ({1'b0, req_addr[gi]} < CELL_LIMIT);
        end
    endgenerate

    logic                 last_grant_reg, last_grant_next;
    logic                 grant_id_reg, grant_id_next;
    logic                 we_reg, we_next;
    logic                 in_range_reg, in_range_next;
    logic                 cs_bar_reg, cs_bar_next;
    logic                 we_bar_reg, we_bar_next;
    logic [AW-1:0]        mem_addr_reg, mem_addr_next;
    logic [WORD_SIZE-1:0] mem_din_reg, mem_din_next;
    logic [1:0]           ready;
    logic                 pick;
    logic                 capture;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        we_next         = we_reg;
        in_range_next   = in_range_reg;
        cs_bar_next     = 1'b1;
        we_bar_next     = 1'b1;
        mem_addr_next   = mem_addr_reg;
        mem_din_next    = mem_din_reg;
        ready           = 2'b00;
        capture         = 1'b0;
        pick            = (&req_valid) ? ~last_grant_reg : req_valid[1];

        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    ready           = pick ? 2'b10 : 2'b01;
                    grant_id_next   = pick;
                    last_grant_next = pick;
                    we_next         = req_we[pick];
                    in_range_next   = req_in_range[pick];
                    mem_addr_next   = req_addr[pick];
                    // Strobes are registered, so the ISSUE-cycle values are set here.
                    cs_bar_next     = ~req_in_range[pick];
                    we_bar_next     = ~(req_we[pick] & req_in_range[pick]);
                    if (req_we[pick]) begin
                        mem_din_next = req_wdata[pick];
                    end
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = IDLE;
                end else begin
                    state_next  = WAIT;
                    cs_bar_next = ~in_range_reg;
                end
            end
            WAIT: begin
                state_next = IDLE;
                capture    = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_id_reg   <= 1'b0;
            we_reg         <= 1'b0;
            in_range_reg   <= 1'b0;
            cs_bar_reg     <= 1'b1;
            we_bar_reg     <= 1'b1;
            mem_addr_reg   <= '0;
            mem_din_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            we_reg         <= we_next;
            in_range_reg   <= in_range_next;
            cs_bar_reg     <= cs_bar_next;
            we_bar_reg     <= we_bar_next;
            mem_addr_reg   <= mem_addr_next;
            mem_din_reg    <= mem_din_next;
        end
    end

    // Sampling at the end of WAIT works for both combinational and one-cycle registered chips.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic                 rvalid_reg;
            logic [WORD_SIZE-1:0] rdata_reg;
            logic                 hit;

            assign hit = capture && (grant_id_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= hit;
                    if (hit) begin
                        rdata_reg <= in_range_reg ? bus.mem_DataOut : '0;
                    end
                end
            end
        end
    endgenerate

    assign bus.r0_ready    = ready[0];
    assign bus.r1_ready    = ready[1];
    assign bus.r0_rvalid   = g_resp[0].rvalid_reg;
    assign bus.r0_rdata    = g_resp[0].rdata_reg;
    assign bus.r1_rvalid   = g_resp[1].rvalid_reg;
    assign bus.r1_rdata    = g_resp[1].rdata_reg;
    assign bus.mem_CS_bar  = cs_bar_reg;
    assign bus.mem_WE_bar  = we_bar_reg;
    assign bus.mem_Address = mem_addr_reg;
    assign bus.mem_DataIn  = mem_din_reg;
    assign bus.busy        = (state_reg != IDLE);
endmodule
